// File: rtl/vt52_pkg.sv
// Shared constants, FSM state type and circular-address helper for the VT52-style
// character buffer writer.
package vt52_pkg;

   localparam int ROWS      = 24;
   localparam int COLS      = 80;
   localparam int ROW_BITS  = 5;
   localparam int COL_BITS  = 7;
   localparam int ADDR_BITS = 11;
   localparam int BUF_SIZE  = ROWS * COLS;

   localparam logic [7:0] CHR_BS    = 8'h08;
   localparam logic [7:0] CHR_LF    = 8'h0A;
   localparam logic [7:0] CHR_CR    = 8'h0D;
   localparam logic [7:0] CHR_SPACE = 8'h20;
   localparam logic [7:0] CHR_TILDE = 8'h7E;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_CLEAR
   } state_t;

   // a + b modulo BUF_SIZE, both operands already below BUF_SIZE; one extra bit
   // holds the carry so the compare sees the true sum.
   function automatic logic [ADDR_BITS-1:0] addr_wrap_add(input logic [ADDR_BITS-1:0] a,
                                                          input logic [ADDR_BITS-1:0] b);
      logic [ADDR_BITS:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (ADDR_BITS+1)'(BUF_SIZE))
         s = s - (ADDR_BITS+1)'(BUF_SIZE);
      return s[ADDR_BITS-1:0];
   endfunction

endpackage

// File: rtl/char_buffer_writer_blink.sv
// Cursor blink phase generator: toggles blink_on every BLINK_CYCLES clocks, and
// restart forces the phase visible and restarts the count.
module cursor_blink_timer #(
   parameter int BLINK_CYCLES = 24000000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic blink_on
);

   localparam int            CW   = $clog2(BLINK_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(BLINK_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          r_on;

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         r_cnt <= '0;
         r_on  <= 1'b1;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
         r_on  <= ~r_on;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign blink_on = r_on;

endmodule

// File: rtl/char_buffer_writer.sv
// Write side of the 80x24 circular character buffer: prints, CR/LF/BS, scroll-and-clear.
// Define CURSOR_BLINK_EN to build the cursor blink timer; otherwise the cursor is always on.
module char_buffer_writer
   import vt52_pkg::*;
#(
   parameter int BLINK_CYCLES = 24000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 wr_en,
   output logic [ADDR_BITS-1:0] wr_addr,
   output logic [7:0]           wr_data,
   output logic [COL_BITS-1:0]  cursor_x,
   output logic [ROW_BITS-1:0]  cursor_y,
   output logic                 cursor_blink_on,
   output logic [ADDR_BITS-1:0] first_char
);

   localparam logic [ADDR_BITS-1:0] A_COLS     = ADDR_BITS'(COLS);
   localparam logic [ADDR_BITS-1:0] A_BUF_LAST = ADDR_BITS'(BUF_SIZE - 1);
   localparam logic [ADDR_BITS-1:0] A_ROW_LAST = ADDR_BITS'(COLS - 1);
   localparam logic [COL_BITS-1:0]  X_LAST     = COL_BITS'(COLS - 1);
   localparam logic [ROW_BITS-1:0]  Y_LAST     = ROW_BITS'(ROWS - 1);

   if (BLINK_CYCLES < 1) begin : g_bad_blink
      $error("BLINK_CYCLES must be at least 1");
   end

   state_t                r_state,    w_state_nx;
   logic [ADDR_BITS-1:0]  r_cnt,      w_cnt_nx;
   logic [ADDR_BITS-1:0]  r_row_base, w_row_base_nx;
   logic [ADDR_BITS-1:0]  r_first,    w_first_nx;
   logic [COL_BITS-1:0]   r_cx,       w_cx_nx;
   logic [ROW_BITS-1:0]   r_cy,       w_cy_nx;
   logic                  r_wr_en,    w_wr_en_nx;
   logic [ADDR_BITS-1:0]  r_wr_addr,  w_wr_addr_nx;
   logic [7:0]            r_wr_data,  w_wr_data_nx;
   logic                  w_accept;

   assign w_accept = in_valid && (r_state == ST_IDLE);

   always_comb begin
      w_state_nx    = r_state;
      w_cnt_nx      = r_cnt;
      w_row_base_nx = r_row_base;
      w_first_nx    = r_first;
      w_cx_nx       = r_cx;
      w_cy_nx       = r_cy;
      w_wr_en_nx    = 1'b0;
      w_wr_addr_nx  = r_wr_addr;
      w_wr_data_nx  = r_wr_data;
      case (r_state)
         ST_INIT: begin
            w_wr_en_nx   = 1'b1;
            w_wr_addr_nx = r_cnt;
            w_wr_data_nx = CHR_SPACE;
            if (r_cnt == A_BUF_LAST) begin
               w_cnt_nx   = '0;
               w_state_nx = ST_IDLE;
            end else begin
               w_cnt_nx = r_cnt + ADDR_BITS'(1);
            end
         end
         ST_IDLE: begin
            if (w_accept) begin
               if (in_data >= CHR_SPACE && in_data <= CHR_TILDE) begin
                  w_wr_en_nx   = 1'b1;
                  w_wr_addr_nx = addr_wrap_add(r_row_base, ADDR_BITS'(r_cx));
                  w_wr_data_nx = in_data;
                  if (r_cx != X_LAST)
                     w_cx_nx = r_cx + COL_BITS'(1);
               end else begin
                  case (in_data)
                     CHR_CR: w_cx_nx = '0;
                     CHR_BS: if (r_cx != '0) w_cx_nx = r_cx - COL_BITS'(1);
                     CHR_LF: begin
                        // row_base always moves down a row; on the bottom row that
                        // lands on the oldest row, which becomes the new blank line.
                        w_row_base_nx = addr_wrap_add(r_row_base, A_COLS);
                        if (r_cy != Y_LAST) begin
                           w_cy_nx = r_cy + ROW_BITS'(1);
                        end else begin
                           w_first_nx = addr_wrap_add(r_first, A_COLS);
                           w_cnt_nx   = '0;
                           w_state_nx = ST_CLEAR;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_CLEAR: begin
            w_wr_en_nx   = 1'b1;
            w_wr_addr_nx = addr_wrap_add(r_row_base, r_cnt);
            w_wr_data_nx = CHR_SPACE;
            if (r_cnt == A_ROW_LAST) begin
               w_cnt_nx   = '0;
               w_state_nx = ST_IDLE;
            end else begin
               w_cnt_nx = r_cnt + ADDR_BITS'(1);
            end
         end
         default: w_state_nx = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_INIT;
         r_cnt      <= '0;
         r_row_base <= '0;
         r_first    <= '0;
         r_cx       <= '0;
         r_cy       <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_cnt      <= w_cnt_nx;
         r_row_base <= w_row_base_nx;
         r_first    <= w_first_nx;
         r_cx       <= w_cx_nx;
         r_cy       <= w_cy_nx;
         r_wr_en    <= w_wr_en_nx;
         r_wr_addr  <= w_wr_addr_nx;
         r_wr_data  <= w_wr_data_nx;
      end
   end

   assign in_ready   = (r_state == ST_IDLE);
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign cursor_x   = r_cx;
   assign cursor_y   = r_cy;
   assign first_char = r_first;

`ifdef CURSOR_BLINK_EN
   cursor_blink_timer #(
      .BLINK_CYCLES(BLINK_CYCLES)
   ) u_blink (
      .clk      (clk),
      .reset    (reset),
      .restart  (w_accept),
      .blink_on (cursor_blink_on)
   );
`else
   assign cursor_blink_on = 1'b1;
`endif

endmodule

// File: tb/tb_char_buffer_writer.sv
// Scoreboard bench for char_buffer_writer: expected buffer writes are queued by the
// stimulus side and consumed by an independent write monitor.
module tb_char_buffer_writer;

   typedef struct {
      int a;
      int d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic [7:0]  wr_data;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        cursor_blink_on;
   logic [10:0] first_char;

   wr_t q[$];
   int  n_vec = 0;
   int  n_err = 0;
   int  n_wr  = 0;
   int  m_cx = 0, m_cy = 0, m_first = 0;

   char_buffer_writer #(.BLINK_CYCLES(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .cursor_x        (cursor_x),
      .cursor_y        (cursor_y),
      .cursor_blink_on (cursor_blink_on),
      .first_char      (first_char)
   );

   always #5 clk = ~clk;

   // Write monitor: every wr_en pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (wr_en) begin
         wr_t e;
         n_wr++;
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL wr_unexpected: got addr %0d data %02h, required no write",
                     wr_addr, wr_data);
         end else begin
            e = q.pop_front();
            if (int'(wr_addr) != e.a || int'(wr_data) != e.d) begin
               n_err++;
               $display("FAIL wr: got addr %0d data %02h, required addr %0d data %02h",
                        wr_addr, wr_data, e.a, e.d);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   function automatic int row_base();
      return (m_first + m_cy * 80) % 1920;
   endfunction

   task automatic push(input int a, input int d);
      wr_t e;
      e.a = a;
      e.d = d;
      q.push_back(e);
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!in_ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) chk("ready_timeout", int'(in_ready), 1);
   endtask

   // Updates the reference model, then drives one handshake; returns 1 ns after
   // the accepting edge.
   task automatic send(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         push(row_base() + m_cx, int'(b));
         if (m_cx < 79) m_cx++;
      end else if (b == 8'h0D) begin
         m_cx = 0;
      end else if (b == 8'h08) begin
         if (m_cx > 0) m_cx--;
      end else if (b == 8'h0A) begin
         if (m_cy < 23) m_cy++;
         else begin
            m_first = (m_first + 80) % 1920;
            for (int i = 0; i < 80; i++) push((row_base() + i) % 1920, 32);
         end
      end
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic chk_state(input string name);
      wait_ready();
      @(negedge clk);
      #1;
      chk({name, "_qempty"}, q.size(), 0);
      chk({name, "_x"}, int'(cursor_x), m_cx);
      chk({name, "_y"}, int'(cursor_y), m_cy);
      chk({name, "_first"}, int'(first_char), m_first);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      reset = 1'b1;
      in_valid = 1'b0;
      q.delete();
      m_cx = 0; m_cy = 0; m_first = 0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_wr_data", int'(wr_data), 0);
      chk("rst_cursor", int'({cursor_y, cursor_x}), 0);
      chk("rst_first", int'(first_char), 0);
      chk("rst_blink", int'(cursor_blink_on), 1);
      for (int i = 0; i < 1920; i++) push(i, 32);
      reset = 1'b0;
      chk_state("init");
      chk("init_ready", int'(in_ready), 1);
   endtask

   initial begin
      int cnt;
      int wr0;

      do_reset();

      // First printable char: one cycle after the handshake
      send(8'h41);
      chk("A_wr_en", int'(wr_en), 1);
      chk("A_wr_addr", int'(wr_addr), 0);
      chk("A_wr_data", int'(wr_data), 8'h41);
      chk("A_cx", int'(cursor_x), 1);
      chk_state("A");

      // No autowrap: cursor sticks at the last column
      repeat (82) send(8'h42);
      chk_state("B82");
      chk("B82_cx79", int'(cursor_x), 79);

      send(8'h0D);
      repeat (23) send(8'h0A);
      chk_state("lf23");
      chk("lf23_y", int'(cursor_y), 23);
      chk("lf23_first", int'(first_char), 0);

      // First scroll: blocks input for exactly one row of clears
      send(8'h0A);
      cnt = 0;
      @(negedge clk);
      while (!in_ready && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      chk("scroll_busy_cycles", cnt, 80);
      chk_state("scroll1");
      chk("scroll1_first", int'(first_char), 80);
      send(8'h43);
      chk("C_wr_addr", int'(wr_addr), 0);
      chk_state("C");

      repeat (22) send(8'h0A);
      chk_state("scroll23");
      chk("scroll23_first", int'(first_char), 1840);
      send(8'h0A);
      chk_state("scroll24");
      chk("scroll24_wrap", int'(first_char), 0);

      send(8'h0D);
      send(8'h08);
      chk_state("bs_at0");
      chk("bs_at0_x", int'(cursor_x), 0);
      wr0 = n_wr;
      send(8'h07);
      chk_state("bel");
      chk("bel_no_write", n_wr, wr0);
      send(8'h78);
      send(8'h79);
      send(8'h08);
      chk_state("bs_mid");

`ifdef CURSOR_BLINK_EN
      send(8'h00);
      chk("blink_restart", int'(cursor_blink_on), 1);
      repeat (7) @(posedge clk);
      #1 chk("blink_hold", int'(cursor_blink_on), 1);
      @(posedge clk);
      #1 chk("blink_off", int'(cursor_blink_on), 0);
      send(8'h00);
      chk("blink_forced_on", int'(cursor_blink_on), 1);
      repeat (7) @(posedge clk);
      #1 chk("blink_count_restarted", int'(cursor_blink_on), 1);
      @(posedge clk);
      #1 chk("blink_off2", int'(cursor_blink_on), 0);
`else
      repeat (20) @(posedge clk);
      #1 chk("blink_const", int'(cursor_blink_on), 1);
`endif

      // Reset in the middle of a clear must restart INIT from address 0
      send(8'h0A);
      repeat (10) @(negedge clk);
      chk("clear_busy", int'(in_ready), 0);
      do_reset();
      send(8'h5A);
      chk("post_rst_addr", int'(wr_addr), 0);
      chk_state("final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
